mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux among four requesters.
- Sequences the mux select lines (S1, S0) from registered grant state.
- Includes the 4:1 data path, so D carries the current owner's input bit.
- Sits between four requesting sources and the shared single-bit mux output.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles an owner keeps the grant while another requester is waiting; legal range 1..255.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Req  input  4  request vector; Req[i] high means requester i wants the mux; a requester holds it high for as long as it needs the mux.
- I3  input  1  data input for requester 3.
- I2  input  1  data input for requester 2.
- I1  input  1  data input for requester 1.
- I0  input  1  data input for requester 0.
- Grant  output  4  registered one-hot grant; 0000 when idle.
- S1  output  1  registered mux select, MSB; equals the owner index bit 1.
- S0  output  1  registered mux select, LSB; equals the owner index bit 0.
- Valid  output  1  registered; high when a grant is active.
- D  output  1  combinational; equals I[{S1,S0}] when Valid=1, otherwise 0.

Behaviour:
- Clock and reset: one clock (Clk). Rst is synchronous and active-high.
- Reset state, on the first edge with Rst=1:
  - Grant=0000, S1S0=00, Valid=0, D=0.
  - state=IDLE, HoldCnt=0.
  - Last-owner pointer Ptr=3, so requester 0 has highest priority first.
- Rst dominates every other input, including mid-grant. It clears all state on that edge, and no grant survives it.
- Search rule: scan indices (Ptr+1), (Ptr+2), (Ptr+3), (Ptr+4) mod 4. The first index with Req set wins.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If Req==0000, stay in IDLE; outputs are unchanged (Valid=0, Grant=0000).
  - Otherwise, on the next edge: Grant=onehot(winner), S1S0=winner, Valid=1, Ptr=winner, HoldCnt=0, go to GRANT.
  - Latency: a Req sampled at edge k produces a Grant visible after edge k, i.e. one cycle.
- GRANT: the owner is Ptr. The following checks are evaluated each edge in priority order.
  - a) Req[owner]=0 (voluntary release):
    - If any other Req is set, grant the next winner directly with no bubble cycle, and set HoldCnt=0.
    - Otherwise go to IDLE: Grant=0000, Valid=0. S1S0 keeps its last value.
  - b) Req[owner]=1, HoldCnt==MAX_HOLD-1, and another Req is set (preemption):
    - Grant the next winner via the search rule; the owner is naturally last in order.
    - Set HoldCnt=0.
  - c) Otherwise, keep the grant and set HoldCnt=min(HoldCnt+1, MAX_HOLD-1).
    - HoldCnt saturates, so a lone requester holds the grant indefinitely.
- A requester that drops Req and re-asserts it in the same cycle its grant ends gets no special priority; normal round-robin order applies.
- Changes to Req[i] for a non-owner mid-grant have no effect until a release or preemption event.
- MAX_HOLD=1: under contention the grant rotates every cycle.
- HoldCnt is 8 bits wide. MAX_HOLD=0 or values above 255 are illegal; behaviour for them is not defined.
- Grant is always one-hot or zero. Valid==(Grant!=0000). S1S0==index(Grant) whenever Valid=1.

Test Plan:
- Reset: hold Rst=1 for 2 cycles with Req=1111. Expect Grant=0000, Valid=0, S1S0=00, D=0. Release Rst; one cycle later expect Grant=0001.
- Single requester: Req=0001, I0=1. After 1 edge expect Grant=0001, S1S0=00, Valid=1, D=1. Drop Req to 0000; next edge expect Grant=0000, Valid=0, D=0.
- Full contention with MAX_HOLD=4 and Req=1111 held. Expect Grant 0001 for 4 cycles, then 0010, 0100, 1000, 0001, each for exactly 4 cycles with no idle cycle. S1S0 tracks 00, 01, 10, 11.
- Voluntary release: Req=0101; owner 0 drops Req[0] after 2 cycles of grant. Expect Grant=0100, S1S0=10 on the very next edge. D follows I2.
- Lone holder: Req=1000 for 20 cycles with MAX_HOLD=4. Expect Grant=1000 for all cycles with no release. Then assert Req[1]; expect Grant=0010 on the next edge (HoldCnt already saturated).
- Mid-grant reset: with Grant=0100 active, pulse Rst for 1 cycle. Expect Grant=0000, Valid=0 on that edge. With Req=1111 afterwards, expect the first grant to go to 0001 (Ptr was reset to 3).

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux; Req in, registered Grant/S1/S0/Valid out, D carries the owner's I bit
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  input  logic       I3,
  input  logic       I2,
  input  logic       I1,
  input  logic       I0,
  output logic [3:0] Grant,
  output logic       S1,
  output logic       S0,
  output logic       Valid,
  output logic       D
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d, sel_q, sel_d, win;
  logic [7:0] hold_q, hold_d;
  logic [3:0] grant_q, grant_d, din;
  logic       valid_q, valid_d, sat, other, sw;
  assign din   = {I3, I2, I1, I0};
  assign sat   = hold_q == 8'(MAX_HOLD - 1);
  assign other = |(Req & ~grant_q);
  assign sw    = state_q == IDLE ? |Req : other && (!Req[ptr_q] || sat);
  always_comb begin
    win = ptr_q;
    for (int k = 4; k >= 1; k--)
      if (Req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (sw) begin
      state_d = GRANT;
      ptr_d   = win;
      hold_d  = '0;
      grant_d = 4'b0001 << win;
      sel_d   = win;
      valid_d = 1'b1;
    end else if (state_q == GRANT && !Req[ptr_q]) begin
      state_d = IDLE;
      hold_d  = '0;
      grant_d = '0;
      valid_d = 1'b0;
    end else if (state_q == GRANT) begin
      hold_d = sat ? hold_q : hold_q + 8'd1;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end
  assign Grant = grant_q;
  assign S1    = sel_q[1];
  assign S0    = sel_q[0];
  assign Valid = valid_q;
  assign D     = valid_q & din[sel_q];
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scoreboard bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;
  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       d;
    string      n;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic [3:0] grant;
  logic       s1, s0, valid, d;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .Clk(clk), .Rst(rst), .Req(req),
    .I3(din[3]), .I2(din[2]), .I1(din[1]), .I0(din[0]),
    .Grant(grant), .S1(s1), .S0(s0), .Valid(valid), .D(d)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({grant, s1, s0, valid, d} !== {e.g, e.s, e.v, e.d}) begin
        errors++;
        $display("FAIL %s: got grant=%b sel=%b%b valid=%b d=%b, expected grant=%b sel=%b valid=%b d=%b",
                 e.n, grant, s1, s0, valid, d, e.g, e.s, e.v, e.d);
      end
    end
  end
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] di,
                      input logic [3:0] g, input logic [1:0] s, input logic v,
                      input logic dd, input string n);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    din = di;
    e = '{g, s, v, dd, n};
    q.push_back(e);
  endtask
  initial begin
    logic [3:0] pat;
    pat = 4'b1010;
    step(1, 4'b1111, pat, 4'b0000, 2'b00, 0, 0, "reset0");
    step(1, 4'b1111, pat, 4'b0000, 2'b00, 0, 0, "reset1");
    for (int j = 0; j < 17; j++) begin
      automatic int o = (j / 4) % 4;
      automatic logic [1:0] oi = o[1:0];
      step(0, 4'b1111, pat, 4'b0001 << oi, oi, 1, pat[oi], "contention");
    end
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 0, 0, "reset_single");
    step(0, 4'b0001, 4'b0001, 4'b0001, 2'b00, 1, 1, "single_grant");
    step(0, 4'b0000, 4'b1111, 4'b0000, 2'b00, 0, 0, "single_release");
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 0, 0, "reset_vol");
    step(0, 4'b0101, 4'b0100, 4'b0001, 2'b00, 1, 0, "vol_grant0");
    step(0, 4'b0101, 4'b0100, 4'b0001, 2'b00, 1, 0, "vol_hold0");
    step(0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1, "vol_handoff");
    step(0, 4'b0100, 4'b0000, 4'b0100, 2'b10, 1, 0, "vol_d_follows_i2");
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 0, 0, "reset_lone");
    for (int j = 0; j < 20; j++)
      step(0, 4'b1000, 4'b1000, 4'b1000, 2'b11, 1, 1, "lone_holder");
    step(0, 4'b1010, 4'b1000, 4'b0010, 2'b01, 1, 0, "lone_preempt");
    step(0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1, 1, "to_owner2");
    step(1, 4'b1111, 4'b1111, 4'b0000, 2'b00, 0, 0, "mid_reset");
    step(0, 4'b1111, 4'b1111, 4'b0001, 2'b00, 1, 1, "after_reset");
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
